// File: rtl/mult_unit.sv
// mult_unit
//   Sequential WIDTH x WIDTH unsigned shift-add multiplier with HI/LO result
//   registers, placed beside the ALU in the EX stage.
//
//   A MULTU takes WIDTH iterations, one per cycle. While it runs, the unit
//   ignores every other unit op and raises stall so the pipeline holds that op.
//   MFHI/MFLO return the HI/LO register through a registered dataOut port.
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   op       00 NOP, 01 MULTU, 10 MFHI, 11 MFLO (sampled every cycle)
//   dataA    multiplicand (rs)
//   dataB    multiplier (rt)
//   busy     high while a multiply is iterating
//   stall    combinational: a unit op is presented while a multiply is running
//   done     one-cycle pulse when HI/LO have just been written
//   dataOut  registered MFHI/MFLO result
//   valid    one-cycle pulse: dataOut was updated by the last edge
module mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] dataOut,
  output logic             valid
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_MFHI  = 2'b10;
  localparam logic [1:0] OP_MFLO  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t               state_r;
  logic [WIDTH-1:0]     hi_r;
  logic [WIDTH-1:0]     lo_r;
  logic [2*WIDTH-1:0]   product_r;
  logic [2*WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]     mplier_r;
  logic [CW-1:0]        count_r;
  logic [WIDTH-1:0]     data_out_r;
  logic                 valid_r;
  logic                 done_r;
  logic                 busy_r;

  logic [2*WIDTH-1:0]   sum_s;
  logic                 stall_s;

  // Partial product for this iteration; the carry out of the top bit cannot
  // occur for unsigned WIDTH x WIDTH operands and is dropped.
  always_comb begin
    sum_s = product_r;
    if (mplier_r[0]) begin
      sum_s = product_r + mcand_r;
    end else begin
      sum_s = product_r;
    end
  end

  // Stall is deliberately unregistered so it drops in the DONE cycle itself.
  always_comb begin
    stall_s = 1'b0;
    if ((op != OP_NOP) && (state_r == ST_RUN)) begin
      stall_s = 1'b1;
    end else begin
      stall_s = 1'b0;
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      hi_r       <= '0;
      lo_r       <= '0;
      product_r  <= '0;
      mcand_r    <= '0;
      mplier_r   <= '0;
      count_r    <= '0;
      data_out_r <= '0;
      valid_r    <= 1'b0;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      done_r  <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          case (op)
            OP_MULTU: begin
              mcand_r   <= {{WIDTH{1'b0}}, dataA};
              mplier_r  <= dataB;
              product_r <= '0;
              count_r   <= '0;
              busy_r    <= 1'b1;
              state_r   <= ST_RUN;
            end
            OP_MFHI: begin
              data_out_r <= hi_r;
              valid_r    <= 1'b1;
              state_r    <= ST_IDLE;
            end
            OP_MFLO: begin
              data_out_r <= lo_r;
              valid_r    <= 1'b1;
              state_r    <= ST_IDLE;
            end
            default: begin
              state_r <= ST_IDLE;
            end
          endcase
        end
        ST_RUN: begin
          product_r <= sum_s;
          mcand_r   <= mcand_r << 1;
          mplier_r  <= mplier_r >> 1;
          count_r   <= count_r + CW'(1);
          // The final iteration commits the product including its own add.
          if (count_r == LAST_CNT) begin
            hi_r    <= sum_s[2*WIDTH-1:WIDTH];
            lo_r    <= sum_s[WIDTH-1:0];
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_RUN;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_r;
  assign stall   = stall_s;
  assign done    = done_r;
  assign dataOut = data_out_r;
  assign valid   = valid_r;

endmodule

// File: tb/tb_mult_unit.sv
module tb_mult_unit;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_MFHI  = 2'b10;
  localparam logic [1:0] OP_MFLO  = 2'b11;

  logic        clk;
  logic        rst;
  logic [1:0]  op;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] dataOut;
  logic        valid;

  int checks = 0;
  int errors = 0;

  // Reference model: HI/LO as the architecture defines them.
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mult_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .op     (op),
    .dataA  (dataA),
    .dataB  (dataB),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .dataOut(dataOut),
    .valid  (valid)
  );

  always #5 clk = ~clk;

  task automatic model_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    m_hi = p[63:32];
    m_lo = p[31:0];
  endtask

  // Read HI or LO; called in IDLE or DONE. Checks the 1-cycle result and hold.
  task automatic read_reg(input logic [1:0] rop, input logic [31:0] exp, input string nm);
    op = rop;
    @(posedge clk); #1;
    op = OP_NOP;
    checks++;
    if (dataOut !== exp || valid !== 1'b1) begin
      errors++;
      $display("FAIL %s read: dataOut=%h valid=%b, expected dataOut=%h valid=1", nm, dataOut, valid, exp);
    end
    @(posedge clk); #1;
    checks++;
    if (dataOut !== exp || valid !== 1'b0) begin
      errors++;
      $display("FAIL %s hold: dataOut=%h valid=%b, expected dataOut=%h valid=0", nm, dataOut, valid, exp);
    end
  endtask

  // Issue a MULTU and wait for done; checks busy length and done timing.
  task automatic mul_and_wait(input logic [31:0] a, input logic [31:0] b, input string nm);
    int busy_cnt;
    int done_at;
    dataA = a;
    dataB = b;
    op = OP_MULTU;
    @(posedge clk); #1;
    op = OP_NOP;
    busy_cnt = (busy === 1'b1) ? 1 : 0;
    done_at = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        done_at = k;
        break;
      end
      if (busy === 1'b1) busy_cnt++;
    end
    checks++;
    if (done_at != 32 || busy_cnt != 32 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s timing: done_at=%0d busy_cycles=%0d busy_now=%b, expected 32/32/0", nm, done_at, busy_cnt, busy);
    end
    model_mul(a, b);
  endtask

  task automatic test_reset;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || valid !== 1'b0 || stall !== 1'b0 || dataOut !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b valid=%b stall=%b dataOut=%h, expected all 0", busy, done, valid, stall, dataOut);
    end
    m_hi = 32'h0;
    m_lo = 32'h0;
    read_reg(OP_MFHI, m_hi, "reset_hi");
    read_reg(OP_MFLO, m_lo, "reset_lo");
  endtask

  task automatic test_basic;
    mul_and_wait(32'd3, 32'd5, "mul_3x5");
    read_reg(OP_MFLO, m_lo, "mul_3x5_lo");
    read_reg(OP_MFHI, m_hi, "mul_3x5_hi");
  endtask

  task automatic test_corners;
    mul_and_wait(32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_max");
    read_reg(OP_MFHI, m_hi, "mul_max_hi");
    read_reg(OP_MFLO, m_lo, "mul_max_lo");
    mul_and_wait(32'h8000_0000, 32'd2, "mul_msb");
    read_reg(OP_MFHI, m_hi, "mul_msb_hi");
    read_reg(OP_MFLO, m_lo, "mul_msb_lo");
  endtask

  task automatic test_random;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = $urandom;
      mul_and_wait(a, b, "mul_rand");
      read_reg(OP_MFLO, m_lo, "mul_rand_lo");
      read_reg(OP_MFHI, m_hi, "mul_rand_hi");
    end
  endtask

  task automatic test_stall_read;
    int  stall_cnt;
    bit  saw_valid;
    bit  got_done;
    dataA = 32'd7;
    dataB = 32'd6;
    op = OP_MULTU;
    @(posedge clk); #1;
    op = OP_NOP;
    model_mul(32'd7, 32'd6);
    @(posedge clk); #1;
    op = OP_MFLO;
    stall_cnt = 0;
    saw_valid = 1'b0;
    got_done  = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      #1;
      if (valid !== 1'b0) saw_valid = 1'b1;
      if (done === 1'b1) begin
        got_done = 1'b1;
        break;
      end
      if (stall === 1'b1) stall_cnt++;
      @(posedge clk); #1;
    end
    checks++;
    if (got_done !== 1'b1 || stall_cnt != 31 || saw_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_run: done_seen=%b stall_cycles=%0d valid_seen=%b, expected 1/31/0", got_done, stall_cnt, saw_valid);
    end
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL stall_done: stall=%b, expected 0", stall);
    end
    @(posedge clk); #1;
    op = OP_NOP;
    checks++;
    if (dataOut !== m_lo || valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_read: dataOut=%h valid=%b, expected dataOut=%h valid=1", dataOut, valid, m_lo);
    end
  endtask

  task automatic test_reset_mid_run;
    dataA = 32'd9;
    dataB = 32'd9;
    op = OP_MULTU;
    @(posedge clk); #1;
    op = OP_NOP;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || dataOut !== 32'h0 || valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run: busy=%b dataOut=%h valid=%b done=%b, expected all 0", busy, dataOut, valid, done);
    end
    m_hi = 32'h0;
    m_lo = 32'h0;
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    read_reg(OP_MFLO, m_lo, "after_abort_lo");
    read_reg(OP_MFHI, m_hi, "after_abort_hi");
  endtask

  task automatic test_back_to_back;
    int done_at;
    dataA = 32'd2;
    dataB = 32'd3;
    op = OP_MULTU;
    @(posedge clk); #1;
    dataA = 32'd4;
    dataB = 32'd4;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL b2b_stall: stall=%b, expected 1", stall);
    end
    done_at = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        done_at = k;
        break;
      end
    end
    checks++;
    if (done_at != 32 || stall !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: done_at=%0d stall=%b, expected 32/0", done_at, stall);
    end
    @(posedge clk); #1;
    op = OP_NOP;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b done=%b, expected 1/0", busy, done);
    end
    done_at = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        done_at = k;
        break;
      end
    end
    checks++;
    if (done_at != 32) begin
      errors++;
      $display("FAIL b2b_second: done_at=%0d, expected 32", done_at);
    end
    model_mul(32'd4, 32'd4);
    read_reg(OP_MFLO, m_lo, "b2b_lo");
    read_reg(OP_MFHI, m_hi, "b2b_hi");
  endtask

  task automatic test_zero;
    mul_and_wait(32'h1234_5678, 32'h0, "mul_b0");
    read_reg(OP_MFLO, m_lo, "mul_b0_lo");
    read_reg(OP_MFHI, m_hi, "mul_b0_hi");
    mul_and_wait(32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_prefill");
    mul_and_wait(32'h0, 32'hDEAD_BEEF, "mul_a0");
    read_reg(OP_MFLO, m_lo, "mul_a0_lo");
    read_reg(OP_MFHI, m_hi, "mul_a0_hi");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    clk   = 1'b0;
    rst   = 1'b0;
    op    = OP_NOP;
    dataA = 32'h0;
    dataB = 32'h0;
    #23;
    rst = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_corners();
    test_random();
    test_stall_read();
    test_reset_mid_run();
    test_back_to_back();
    test_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
